// File: rtl/vga_tile_pkg.sv
// Shared constants for the VGA tile path: 8x8 tiles on a 64x32 wrapping map.
// No logic; latency and backpressure are defined by the blocks that import this.
package vga_tile_pkg;
  localparam int TILE_LOG2      = 3;
  localparam int MAP_COLS_LOG2  = 6;
  localparam int MAP_ROWS_LOG2  = 5;
  localparam int BG_LATENCY     = 5;
  localparam int SCROLL_X_WIDTH = TILE_LOG2 + MAP_COLS_LOG2;
  localparam int SCROLL_Y_WIDTH = TILE_LOG2 + MAP_ROWS_LOG2;

  // Per-pixel side information that rides alongside the two memory reads.
  typedef struct packed {
    logic                 de;
    logic                 hsync;
    logic                 vsync;
    logic [TILE_LOG2-1:0] fine_x;
  } px_meta_t;
endpackage

// File: rtl/bg_delay_line.sv
// Fixed-depth register shift line with a parameterised reset value.
// Latency DEPTH clocks, always advancing, no backpressure.
module bg_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;

  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= {DEPTH{RST_VAL}};
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[DEPTH-1];
endmodule

// File: rtl/bg_tile_fetch.sv
// Background tile fetcher: pixel coordinate -> name table -> pattern ROM -> colour.
// Latency 5 clocks, one pixel per clock, no stalls or backpressure.
module bg_tile_fetch
  import vga_tile_pkg::*;
#(
  parameter int NAME_ADDR_WIDTH = 11,
  parameter int TILE_IDX_WIDTH  = 8,
  parameter int PAT_ADDR_WIDTH  = 11,
  parameter int COLOR_WIDTH     = 8,
  parameter bit SYNC_POL        = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [9:0]                 px_x,
  input  logic [9:0]                 px_y,
  input  logic                       de_in,
  input  logic                       hsync_in,
  input  logic                       vsync_in,
  input  logic [SCROLL_X_WIDTH-1:0]  scroll_x_in,
  input  logic [SCROLL_Y_WIDTH-1:0]  scroll_y_in,
  input  logic [COLOR_WIDTH-1:0]     fg_color,
  input  logic [COLOR_WIDTH-1:0]     bg_color,
  output logic [NAME_ADDR_WIDTH-1:0] name_addr,
  input  logic [TILE_IDX_WIDTH-1:0]  name_data,
  output logic [PAT_ADDR_WIDTH-1:0]  pat_addr,
  input  logic [7:0]                 pat_data,
  output logic [COLOR_WIDTH-1:0]     rgb_out,
  output logic                       de_out,
  output logic                       hsync_out,
  output logic                       vsync_out
);
  localparam bit SYNC_IDLE = !SYNC_POL;

  logic [SCROLL_X_WIDTH-1:0]  scroll_x_q, scroll_x_d;
  logic [SCROLL_Y_WIDTH-1:0]  scroll_y_q, scroll_y_d;
  logic                       vs_prev_q, vs_prev_d;
  logic                       armed_q, armed_d;
  logic [NAME_ADDR_WIDTH-1:0] name_addr_q, name_addr_d;
  logic [PAT_ADDR_WIDTH-1:0]  pat_addr_q, pat_addr_d;
  logic [COLOR_WIDTH-1:0]     rgb_q, rgb_d;
  logic                       de_q, de_d, hs_q, hs_d, vs_q, vs_d;
  logic [SCROLL_X_WIDTH-1:0]  wx;
  logic [SCROLL_Y_WIDTH-1:0]  wy;
  logic                       pix;
  px_meta_t                   meta_in, meta_dly;
  logic [TILE_LOG2-1:0]       fine_y_dly;
  logic                       unused_px;

  // The map wraps at 512x256, so the upper coordinate bits never matter.
  assign unused_px = ^{px_x[9:SCROLL_X_WIDTH], px_y[9:SCROLL_Y_WIDTH]};

  always_comb begin
    scroll_x_d = scroll_x_q;
    scroll_y_d = scroll_y_q;
    // armed_q blocks a load on the first clock after reset, so a vsync that is
    // already active at release is not mistaken for a fresh assertion.
    if (armed_q && (vs_prev_q != SYNC_POL) && (vsync_in == SYNC_POL)) begin
      scroll_x_d = scroll_x_in;
      scroll_y_d = scroll_y_in;
    end
    vs_prev_d   = vsync_in;
    armed_d     = 1'b1;
    wx          = px_x[SCROLL_X_WIDTH-1:0] + scroll_x_q;
    wy          = px_y[SCROLL_Y_WIDTH-1:0] + scroll_y_q;
    name_addr_d = NAME_ADDR_WIDTH'({wy[SCROLL_Y_WIDTH-1:TILE_LOG2],
                                    wx[SCROLL_X_WIDTH-1:TILE_LOG2]});
    meta_in     = '{de: de_in, hsync: hsync_in, vsync: vsync_in,
                    fine_x: wx[TILE_LOG2-1:0]};
    pat_addr_d  = PAT_ADDR_WIDTH'({name_data, fine_y_dly});
    pix         = pat_data[3'd7 - meta_dly.fine_x];
    rgb_d       = meta_dly.de ? (pix ? fg_color : bg_color) : '0;
    de_d        = meta_dly.de;
    hs_d        = meta_dly.hsync;
    vs_d        = meta_dly.vsync;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scroll_x_q  <= '0;
      scroll_y_q  <= '0;
      vs_prev_q   <= SYNC_IDLE;
      armed_q     <= 1'b0;
      name_addr_q <= '0;
      pat_addr_q  <= '0;
      rgb_q       <= '0;
      de_q        <= 1'b0;
      hs_q        <= SYNC_IDLE;
      vs_q        <= SYNC_IDLE;
    end else begin
      scroll_x_q  <= scroll_x_d;
      scroll_y_q  <= scroll_y_d;
      vs_prev_q   <= vs_prev_d;
      armed_q     <= armed_d;
      name_addr_q <= name_addr_d;
      pat_addr_q  <= pat_addr_d;
      rgb_q       <= rgb_d;
      de_q        <= de_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
    end
  end

  // Side info reaches the output stage together with pat_data (4 edges).
  bg_delay_line #(
    .WIDTH   ($bits(px_meta_t)),
    .DEPTH   (BG_LATENCY - 1),
    .RST_VAL ({1'b0, SYNC_IDLE, SYNC_IDLE, {TILE_LOG2{1'b0}}})
  ) u_meta_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (meta_in),
    .dout (meta_dly)
  );

  // Tile row index must line up with name_data when pat_addr loads (2 edges).
  bg_delay_line #(
    .WIDTH   (TILE_LOG2),
    .DEPTH   (BG_LATENCY - 3),
    .RST_VAL ('0)
  ) u_fine_y_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (wy[TILE_LOG2-1:0]),
    .dout (fine_y_dly)
  );

  assign name_addr = name_addr_q;
  assign pat_addr  = pat_addr_q;
  assign rgb_out   = rgb_q;
  assign de_out    = de_q;
  assign hsync_out = hs_q;
  assign vsync_out = vs_q;
endmodule
